// File: rtl/ctrl_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_resolve_pipe
// Brief    : Pipelined resolution of JAL/JALR/branches/CSR ops with
//            mispredict redirect capture and saturating mispredict counter.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_resolve_pipe #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int IMM_W  = 20,
    parameter int STAGES = 2,
    parameter int TAG_W  = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [IMM_W-1:0]  immd_i,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   predNPC_i,
    input  logic              predDir_i,
    input  logic              destValid_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   result_o,
    output logic [PC_W-1:0]   nextPC_o,
    output logic              direction_o,
    output logic              mispredict_o,
    output logic              destValid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              csrWrEn_o,
    output logic [11:0]       csrWrAddr_o,
    output logic [DATA_W-1:0] csrWrData_o,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    output logic [TAG_W-1:0]  redirect_tag_o,
    input  logic              redirect_ack_i,
    output logic [CNT_W-1:0]  mispredCount_o
);

    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0]   result;
        logic [PC_W-1:0]   npc;
        logic              dir;
        logic              mis;
        logic              dv;
        logic [TAG_W-1:0]  tag;
        logic              csr;
        logic [11:0]       caddr;
        logic [DATA_W-1:0] cdata;
    } stage_t;

    logic [6:0]        w_opcode;
    logic [2:0]        w_fn3;
    logic [PC_W-1:0]   w_imm;
    logic [PC_W-1:0]   w_pc4;
    logic [PC_W-1:0]   w_br_tgt;
    logic [PC_W-1:0]   w_jalr_sum;
    logic [PC_W-1:0]   w_jalr_tgt;
    logic [DATA_W-1:0] w_zimm;
    logic              w_take;
    logic              w_br_ok;
    logic              w_unused;
    stage_t            stage_d;

    assign w_opcode   = inst_i[6:0];
    assign w_fn3      = inst_i[14:12];
    assign w_imm      = {{(PC_W-IMM_W){immd_i[IMM_W-1]}}, immd_i};
    assign w_pc4      = pc_i + PC_W'(4);
    assign w_br_tgt   = pc_i + w_imm;
    assign w_jalr_sum = data1_i[PC_W-1:0] + w_imm;
    assign w_jalr_tgt = {w_jalr_sum[PC_W-1:1], 1'b0};
    assign w_zimm     = {{(DATA_W-5){1'b0}}, inst_i[19:15]};
    assign w_unused   = ^inst_i[11:7];

    always_comb begin
        w_take  = 1'b0;
        w_br_ok = 1'b1;
        case (w_fn3)
            3'b000:  w_take = (data1_i == data2_i);
            3'b001:  w_take = (data1_i != data2_i);
            3'b100:  w_take = ($signed(data1_i) <  $signed(data2_i));
            3'b101:  w_take = ($signed(data1_i) >= $signed(data2_i));
            3'b110:  w_take = (data1_i <  data2_i);
            3'b111:  w_take = (data1_i >= data2_i);
            default: w_br_ok = 1'b0;
        endcase
    end

    // Stage 0: full resolution; unrecognised ops carry only their tag.
    always_comb begin
        stage_d     = '0;
        stage_d.tag = tag_i;
        case (w_opcode)
            c_OP_JAL: begin
                stage_d.dir    = 1'b1;
                stage_d.result = w_pc4;
                stage_d.npc    = predNPC_i;
                stage_d.dv     = destValid_i;
            end
            c_OP_JALR: begin
                stage_d.dir    = 1'b1;
                stage_d.result = w_pc4;
                stage_d.npc    = w_jalr_tgt;
                stage_d.mis    = (w_jalr_tgt != predNPC_i);
                stage_d.dv     = destValid_i;
            end
            c_OP_BRANCH: begin
                if (w_br_ok) begin
                    stage_d.dir = w_take;
                    stage_d.npc = w_take ? w_br_tgt : w_pc4;
                    stage_d.mis = (w_take != predDir_i);
                end
            end
            c_OP_SYSTEM: begin
                if (w_fn3 != 3'b000) begin
                    stage_d.result = data2_i[PC_W-1:0];
                    stage_d.csr    = 1'b1;
                    stage_d.caddr  = inst_i[31:20];
                    stage_d.dv     = destValid_i;
                    case (w_fn3)
                        3'b001:  stage_d.cdata = data1_i;
                        3'b010:  stage_d.cdata = data2_i | data1_i;
                        3'b011:  stage_d.cdata = data2_i & ~data1_i;
                        3'b101:  stage_d.cdata = w_zimm;
                        3'b110:  stage_d.cdata = data2_i | w_zimm;
                        3'b111:  stage_d.cdata = data2_i & ~w_zimm;
                        default: stage_d.cdata = '0;
                    endcase
                end
            end
            default: ;
        endcase
    end

    logic [STAGES-1:0] valid_q;
    stage_t            stage_q [STAGES];
    stage_t            w_last;
    logic              w_stall;
    logic              w_fire;
    logic              w_accept;
    logic              w_capture;

    assign w_last      = stage_q[STAGES-1];
    assign out_valid_o = valid_q[STAGES-1] & ~flush_i;
    assign w_stall     = out_valid_o & ~out_ready_i;
    assign in_ready_o  = ~w_stall & ~reset;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_fire      = out_valid_o & out_ready_i;

    // Whole pipe moves or holds together; bubbles are not squeezed out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (!w_stall) begin
            valid_q[0] <= w_accept;
            stage_q[0] <= w_accept ? stage_d : '0;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign result_o     = w_last.result;
    assign nextPC_o     = w_last.npc;
    assign direction_o  = w_last.dir;
    assign mispredict_o = w_last.mis;
    assign destValid_o  = w_last.dv;
    assign tag_o        = w_last.tag;
    assign csrWrEn_o    = w_fire & w_last.csr;
    assign csrWrAddr_o  = csrWrEn_o ? w_last.caddr : 12'd0;
    assign csrWrData_o  = csrWrEn_o ? w_last.cdata : '0;

    logic              redir_valid_q;
    logic [PC_W-1:0]   redir_pc_q;
    logic [TAG_W-1:0]  redir_tag_q;
    logic [CNT_W-1:0]  count_q;

    // Later mispredicts while one is pending are on the wrong path.
    assign w_capture = w_fire & w_last.mis & (~redir_valid_q | redirect_ack_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_tag_q   <= '0;
            count_q       <= '0;
        end else begin
            if (w_capture) begin
                redir_valid_q <= 1'b1;
                redir_pc_q    <= w_last.npc;
                redir_tag_q   <= w_last.tag;
            end else if (redirect_ack_i) begin
                redir_valid_q <= 1'b0;
            end
            if (w_fire && w_last.mis && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign redirect_tag_o   = redir_tag_q;
    assign mispredCount_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_resolve_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_resolve_pipe
// Brief    : Scoreboard bench for ctrl_resolve_pipe with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_resolve_pipe;

    localparam int DATA_W = 64;
    localparam int PC_W   = 64;
    localparam int IMM_W  = 20;
    localparam int STAGES = 2;
    localparam int TAG_W  = 7;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [IMM_W-1:0]  immd_i;
    logic [31:0]       inst_i;
    logic [PC_W-1:0]   pc_i;
    logic [PC_W-1:0]   predNPC_i;
    logic              predDir_i;
    logic              destValid_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   result_o;
    logic [PC_W-1:0]   nextPC_o;
    logic              direction_o;
    logic              mispredict_o;
    logic              destValid_o;
    logic [TAG_W-1:0]  tag_o;
    logic              csrWrEn_o;
    logic [11:0]       csrWrAddr_o;
    logic [DATA_W-1:0] csrWrData_o;
    logic              redirect_valid_o;
    logic [PC_W-1:0]   redirect_pc_o;
    logic [TAG_W-1:0]  redirect_tag_o;
    logic              redirect_ack_i;
    logic [CNT_W-1:0]  mispredCount_o;

    ctrl_resolve_pipe #(
        .DATA_W(DATA_W), .PC_W(PC_W), .IMM_W(IMM_W),
        .STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i),
        .inst_i(inst_i), .pc_i(pc_i), .predNPC_i(predNPC_i),
        .predDir_i(predDir_i), .destValid_i(destValid_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .nextPC_o(nextPC_o), .direction_o(direction_o),
        .mispredict_o(mispredict_o), .destValid_o(destValid_o), .tag_o(tag_o),
        .csrWrEn_o(csrWrEn_o), .csrWrAddr_o(csrWrAddr_o), .csrWrData_o(csrWrData_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_tag_o(redirect_tag_o), .redirect_ack_i(redirect_ack_i),
        .mispredCount_o(mispredCount_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] npc;
        logic        dir;
        logic        mis;
        logic        dv;
        logic [6:0]  tag;
        logic        csr;
        logic [11:0] caddr;
        logic [63:0] cdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic exp_t mk(input logic [63:0] res, input logic [63:0] npc,
                                input logic dir, input logic mis, input logic dv,
                                input logic [6:0] tag, input logic csr,
                                input logic [11:0] ca, input logic [63:0] cd);
        exp_t e;
        e.res = res; e.npc = npc; e.dir = dir; e.mis = mis; e.dv = dv;
        e.tag = tag; e.csr = csr; e.caddr = ca; e.cdata = cd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op, waits for acceptance; returns 1 ns after the accepting edge.
    task automatic send(input logic [31:0] inst, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [19:0] imm, input logic [63:0] pc, input logic [63:0] pnpc,
                        input logic pdir, input logic dv, input logic [6:0] tag,
                        input logic push, input exp_t e);
        logic ok;
        ok = 1'b0;
        inst_i = inst; data1_i = d1; data2_i = d2; immd_i = imm; pc_i = pc;
        predNPC_i = pnpc; predDir_i = pdir; destValid_i = dv; tag_i = tag;
        in_valid_i = 1'b1;
        if (push) sb_q.push_back(e);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready_o;
            tick();
        end
        in_valid_i = 1'b0;
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout tag %0d: got no in_ready required in_ready=1", tag);
        end
    endtask

    // Monitor: every fire pops and compares one expected response.
    initial begin
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid_o && out_ready_i) begin
                a = mk(result_o, nextPC_o, direction_o, mispredict_o, destValid_o,
                       tag_o, csrWrEn_o, csrWrAddr_o, csrWrData_o);
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got tag %0d required no output", tag_o);
                end else begin
                    e = sb_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL out_tag%0d: got %h required %h", e.tag, a, e);
                    end
                end
            end else if (!reset && csrWrEn_o) begin
                n_vec++;
                n_fail++;
                $display("FAIL csrWrEn_nofire: got 1 required 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] held_res;
        logic        seen;
        reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        redirect_ack_i = 1'b0; data1_i = '0; data2_i = '0; immd_i = '0; inst_i = '0;
        pc_i = '0; predNPC_i = '0; predDir_i = 1'b0; destValid_i = 1'b0; tag_i = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_nextpc", nextPC_o, 0);
        chk("rst_redir_valid", redirect_valid_o, 0);
        chk("rst_count", mispredCount_o, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1);
        tick();

        // BEQ taken, predicted not-taken: latency and redirect capture
        send(32'h00000063, 64'd5, 64'd5, 20'h40, 64'h1000, 64'h1004, 1'b0, 1'b1, 7'd1, 1'b1,
             mk(64'h0, 64'h1040, 1, 1, 0, 7'd1, 0, 12'h0, 64'h0));
        @(negedge clk);
        chk("beq_lat_cycle1", out_valid_o, 0);
        tick();
        @(negedge clk);
        chk("beq_lat_cycle2", out_valid_o, 1);
        tick();
        chk("beq_redir_valid", redirect_valid_o, 1);
        chk("beq_redir_pc", redirect_pc_o, 64'h1040);
        chk("beq_redir_tag", redirect_tag_o, 1);
        chk("beq_count", mispredCount_o, 1);

        send(32'h00000067, 64'h2001, 64'h0, 20'h10, 64'h3000, 64'h2010, 1'b0, 1'b1, 7'd2, 1'b1,
             mk(64'h3004, 64'h2010, 1, 0, 1, 7'd2, 0, 12'h0, 64'h0));
        send(32'h0000006F, 64'h0, 64'h0, 20'h0, 64'h4000, 64'h5000, 1'b0, 1'b1, 7'd3, 1'b1,
             mk(64'h4004, 64'h5000, 1, 0, 1, 7'd3, 0, 12'h0, 64'h0));
        send(32'h30003073, 64'h0F, 64'hFF, 20'h0, 64'h5000, 64'h0, 1'b0, 1'b1, 7'd4, 1'b1,
             mk(64'hFF, 64'h0, 0, 0, 1, 7'd4, 1, 12'h300, 64'hF0));
        send(32'h3412E073, 64'h0, 64'h10, 20'h0, 64'h5004, 64'h0, 1'b0, 1'b1, 7'd5, 1'b1,
             mk(64'h10, 64'h0, 0, 0, 1, 7'd5, 1, 12'h341, 64'h15));
        send(32'h00004063, c_ONES, 64'd1, 20'hFFFF0, 64'h100, 64'h0, 1'b1, 1'b1, 7'd6, 1'b1,
             mk(64'h0, 64'hF0, 1, 0, 0, 7'd6, 0, 12'h0, 64'h0));
        send(32'h00001063, 64'd7, 64'd7, 20'h40, 64'h200, 64'h0, 1'b0, 1'b1, 7'd7, 1'b1,
             mk(64'h0, 64'h204, 0, 0, 0, 7'd7, 0, 12'h0, 64'h0));
        send(32'h00002063, 64'd1, 64'd2, 20'h40, 64'h208, 64'h0, 1'b1, 1'b1, 7'd8, 1'b1,
             mk(64'h0, 64'h0, 0, 0, 0, 7'd8, 0, 12'h0, 64'h0));
        send(32'h0000000F, 64'd1, 64'd2, 20'h40, 64'h20C, 64'h0, 1'b1, 1'b1, 7'd9, 1'b1,
             mk(64'h0, 64'h0, 0, 0, 0, 7'd9, 0, 12'h0, 64'h0));
        repeat (4) tick();
        chk("hold_redir_pc", redirect_pc_o, 64'h1040);
        chk("hold_count", mispredCount_o, 1);

        // BLTU mispredict while redirect pending and no ack: dropped but counted
        send(32'h00006063, c_ONES, 64'd1, 20'h40, 64'h300, 64'h0, 1'b1, 1'b1, 7'd10, 1'b1,
             mk(64'h0, 64'h304, 0, 1, 0, 7'd10, 0, 12'h0, 64'h0));
        repeat (4) tick();
        chk("drop_redir_pc", redirect_pc_o, 64'h1040);
        chk("drop_redir_tag", redirect_tag_o, 1);
        chk("drop_count", mispredCount_o, 2);

        // BGE mispredict with ack in its fire cycle: captured
        send(32'h00005063, 64'd1, 64'd2, 20'h40, 64'h400, 64'h0, 1'b1, 1'b1, 7'd11, 1'b1,
             mk(64'h0, 64'h404, 0, 1, 0, 7'd11, 0, 12'h0, 64'h0));
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid_o;
            if (!seen) tick();
        end
        chk("bge_out_seen", seen, 1);
        redirect_ack_i = 1'b1;
        tick();
        redirect_ack_i = 1'b0;
        chk("ackcap_redir_pc", redirect_pc_o, 64'h404);
        chk("ackcap_redir_tag", redirect_tag_o, 11);
        chk("ackcap_redir_valid", redirect_valid_o, 1);
        chk("ackcap_count", mispredCount_o, 3);
        redirect_ack_i = 1'b1;
        tick();
        redirect_ack_i = 1'b0;
        chk("ack_clear", redirect_valid_o, 0);
        redirect_ack_i = 1'b1;
        tick();
        redirect_ack_i = 1'b0;
        chk("ack_idle", redirect_valid_o, 0);

        // Back-pressure with two ops in flight
        out_ready_i = 1'b0;
        send(32'h30501073, 64'hABCD, 64'h11, 20'h0, 64'h6000, 64'h0, 1'b0, 1'b1, 7'd12, 1'b1,
             mk(64'h11, 64'h0, 0, 0, 1, 7'd12, 1, 12'h305, 64'hABCD));
        send(32'h0000006F, 64'h0, 64'h0, 20'h0, 64'h6004, 64'h7000, 1'b0, 1'b1, 7'd13, 1'b1,
             mk(64'h6008, 64'h7000, 1, 0, 1, 7'd13, 0, 12'h0, 64'h0));
        held_res = result_o;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready_o, 0);
            chk("stall_out_valid", out_valid_o, 1);
            chk("stall_tag", tag_o, 12);
            chk("stall_result", result_o, held_res);
            chk("stall_csrWrEn", csrWrEn_o, 0);
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_first_tag", tag_o, 12);
        tick();
        @(negedge clk);
        chk("release_second_valid", out_valid_o, 1);
        chk("release_second_tag", tag_o, 13);
        tick();

        // Flush with a mispredicting branch at the output
        send(32'h00000063, 64'd3, 64'd3, 20'h40, 64'h8000, 64'h0, 1'b0, 1'b1, 7'd14, 1'b0,
             mk(64'h0, 64'h0, 0, 0, 0, 7'd0, 0, 12'h0, 64'h0));
        send(32'h0000006F, 64'h0, 64'h0, 20'h0, 64'h8004, 64'h9000, 1'b0, 1'b1, 7'd15, 1'b0,
             mk(64'h0, 64'h0, 0, 0, 0, 7'd0, 0, 12'h0, 64'h0));
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        tag_i = 7'd16;
        @(negedge clk);
        chk("flush_out_valid", out_valid_o, 0);
        chk("flush_csrWrEn", csrWrEn_o, 0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_flush_out_valid", out_valid_o, 0);
            tick();
        end
        chk("flush_no_capture", redirect_valid_o, 0);
        chk("flush_count", mispredCount_o, 3);

        send(32'h0000006F, 64'h0, 64'h0, 20'h0, 64'hA000, 64'hB000, 1'b0, 1'b0, 7'd17, 1'b1,
             mk(64'hA004, 64'hB000, 1, 0, 0, 7'd17, 0, 12'h0, 64'h0));
        send(32'h00000063, 64'd9, 64'd9, 20'h20, 64'hC000, 64'h0, 1'b0, 1'b1, 7'd18, 1'b1,
             mk(64'h0, 64'hC020, 1, 1, 0, 7'd18, 0, 12'h0, 64'h0));
        repeat (4) tick();
        chk("pre_reset_redir", redirect_pc_o, 64'hC020);
        chk("pre_reset_count", mispredCount_o, 4);

        // Asynchronous reset with an op in flight
        send(32'h0000006F, 64'h0, 64'h0, 20'h0, 64'hD000, 64'hE000, 1'b0, 1'b1, 7'd19, 1'b0,
             mk(64'h0, 64'h0, 0, 0, 0, 7'd0, 0, 12'h0, 64'h0));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid_o, 0);
        chk("midrst_redir", redirect_valid_o, 0);
        chk("midrst_count", mispredCount_o, 0);
        tick();
        reset = 1'b0;
        repeat (4) tick();

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
        chk("sb_drained", 64'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_resolve_pipe.md
Name: ctrl_resolve_pipe

Overview:
- Parametrised, pipelined control-resolution unit for the control execution lane.
- Resolves JAL/JALR/conditional branches and CSR read-modify-write ops (RISC-V encodings), and detects mispredicts.
- Carries results through STAGES registered stages with valid/ready back-pressure.
- Holds the first mispredict redirect until fetch acknowledges it; keeps a saturating mispredict counter.

Parameters:
- DATA_W, 64, width of data1/data2/csr data.
- PC_W, 64, width of PC/result (PC_W >= 32, PC_W <= DATA_W).
- IMM_W, 20, immediate width; sign-extended to PC_W.
- STAGES, 2, pipeline depth 1..4 (latency in cycles).
- TAG_W, 7, ROB/age tag width.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush_i  in  1  kill all in-flight ops
- in_valid_i  in  1  op present
- in_ready_o  out  1  unit accepts op
- data1_i  in  DATA_W  rs1 value
- data2_i  in  DATA_W  rs2 value / old CSR value
- immd_i  in  IMM_W  immediate
- inst_i  in  32  instruction
- pc_i  in  PC_W  instruction PC
- predNPC_i  in  PC_W  predicted target
- predDir_i  in  1  predicted direction
- destValid_i  in  1  op writes rd
- tag_i  in  TAG_W  op tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- result_o  out  PC_W  rd value
- nextPC_o  out  PC_W  resolved next PC
- direction_o  out  1  resolved direction
- mispredict_o  out  1  op mispredicted
- destValid_o  out  1  rd write enable
- tag_o  out  TAG_W  op tag
- csrWrEn_o  out  1  CSR write strobe
- csrWrAddr_o  out  12  CSR address (inst[31:20])
- csrWrData_o  out  DATA_W  CSR write data
- redirect_valid_o  out  1  redirect pending
- redirect_pc_o  out  PC_W  redirect target
- redirect_tag_o  out  TAG_W  tag of mispredicting op
- redirect_ack_i  in  1  fetch consumed redirect
- mispredCount_o  out  CNT_W  saturating mispredict count

Behaviour:
- Reset: every stage valid = 0; all outputs 0 (in_ready_o = 1 once reset deasserts); redirect pending cleared; counter = 0.
- Stage 0 computes combinationally from the inputs; stages 1..STAGES-1 only delay. Output is the last stage register, so latency = STAGES cycles with no stall.
- Common terms: imm = sign-extend immd_i; pc4 = pc_i + 4. All adds modulo 2^PC_W.
- JAL (1101111): dir = 1, result = pc4, nextPC = predNPC_i, mispredict = 0.
- JALR (1100111): dir = 1, result = pc4, nextPC = (data1 + imm) with bit 0 cleared, mispredict = (nextPC != predNPC_i).
- BRANCH (1100011): fn3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - nextPC = dir ? pc_i + imm : pc4; mispredict = (dir != predDir_i); destValid = 0.
  - fn3 010/011: op passes with all result fields 0.
- SYSTEM (1110011), fn3 != 000: result = data2; csrWrAddr = inst[31:20]; csr flag = 1; destValid = destValid_i.
  - Write data by fn3: 001 data1; 010 data2 | data1; 011 data2 & ~data1; 101 zimm; 110 data2 | zimm; 111 data2 & ~zimm.
  - zimm = inst[19:15] zero-extended.
- SYSTEM fn3 000, MISC_MEM, and all other opcodes: executed with all result fields 0.
- Handshake and stall: stall = out_valid_o & !out_ready_i; in_ready_o = !stall. When stalled, all stages hold and bubbles are not collapsed. Accept = in_valid_i & in_ready_o.
- Fire = out_valid_o & out_ready_i. csrWrEn_o = fire & csr flag; csrWrAddr_o and csrWrData_o are 0 when csrWrEn_o = 0.
- flush_i has priority:
  - all stage valids clear at the next edge and any input that cycle is discarded;
  - out_valid_o and csrWrEn_o are forced 0 during the flush cycle;
  - there is no capture and no count during the flush cycle;
  - the redirect register is unaffected.
- Redirect capture: on fire with mispredict_o = 1, if no redirect is pending or redirect_ack_i is asserted that cycle, load redirect_pc = nextPC and redirect_tag = tag, and set pending. Otherwise the new mispredict is dropped (wrong path).
- Redirect clear: redirect_ack_i with no simultaneous capture clears pending. An ack while not pending is ignored.
- Counter: +1 on every fire with mispredict_o = 1 (captured or dropped); saturates at all-ones.
- Reset mid-operation: immediate asynchronous return to reset state; in-flight ops are lost.

Test Plan:
- STAGES=2, BEQ with data1 = data2 = 5, pc = 0x1000, imm = 0x40, predDir = 0 -> two cycles later out_valid = 1, nextPC = 0x1040, mispredict = 1; redirect_valid = 1, redirect_pc = 0x1040; counter = 1.
- JALR with data1 = 0x2001, imm = 0x10, predNPC = 0x2010 -> nextPC = 0x2010, mispredict = 0, result = pc + 4, no redirect.
- CSRRC (fn3 011) with data2 = 0xFF, data1 = 0x0F, inst[31:20] = 0x300, out_ready = 1 -> csrWrEn pulses 1 cycle, csrWrData = 0xF0, result = 0xFF.
- out_ready = 0 for 3 cycles with 2 ops in flight -> in_ready = 0, outputs stable, no csrWrEn; on release the ops emerge in order on consecutive cycles.
- Redirect pending and a second mispredict fires with no ack -> redirect_pc unchanged, counter +1. Repeat with ack in the same cycle -> new target captured.
- flush_i asserted with 2 valid stages, one a mispredicting branch at output -> out_valid = 0 that cycle and after, no redirect capture, counter unchanged.
